// File: rtl/mole_game_pkg.sv
// Shared definitions for the mole game controller.
// Contents:
//   state_t     - round sequencer states
//   LFSR_TAPS   - feedback mask for the 8-bit Fibonacci LFSR (taps 8,6,5,4)
//   idx_width() - width of a mole index for a given mole count (minimum 1)
package mole_game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        UP,
        COOL,
        GAME_OVER
    } state_t;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_edge_bank.sv
// Registered rising-edge detector for a bank of debounced button levels.
// Ports:
//   clk       in   system clock
//   n_reset   in   synchronous active-low reset
//   btn       in   N button levels
//   btn_rise  out  N combinational rising-edge flags (btn & ~previous btn)
module btn_edge_bank #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic [N-1:0] btn,
    output logic [N-1:0] btn_rise
);

    logic [N-1:0] btn_q;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            btn_q <= '0;
        end else begin
            btn_q <= btn;
        end
    end

    assign btn_rise = btn & ~btn_q;

endmodule

// File: rtl/mole_round_scheduler.sv
// Whack-a-mole round sequencer: picks a pseudo-random mole, holds it up for
// UP_CYCLES, judges presses as hit/miss, keeps score and miss counters.
// Optional feature macro: MOLE_PENALTY_EN (wrong-button presses count as misses).
// Ports:
//   clk, n_reset      clock and synchronous active-low reset
//   run               level, game running
//   clear             pulse, zero score/misses, leave GAME_OVER
//   btn               debounced button levels
//   mole_onehot       raised mole (one-hot, zero outside UP)
//   hit_pulse         one-cycle pulse on a correct hit
//   miss_pulse        one-cycle pulse on a miss
//   score, misses     hit count (saturating) and miss count
//   game_over         high while in GAME_OVER
module mole_round_scheduler
    import mole_game_pkg::*;
#(
    parameter int unsigned N_MOLES     = 4,
    parameter int unsigned UP_CYCLES   = 50000000,
    parameter int unsigned COOL_CYCLES = 25000000,
    parameter int unsigned SCORE_W     = 8,
    parameter int unsigned MAX_MISSES  = 5,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               run,
    input  logic               clear,
    input  logic [N_MOLES-1:0] btn,
    output logic [N_MOLES-1:0] mole_onehot,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] misses,
    output logic               game_over
);

    localparam int unsigned IDX_W   = idx_width(N_MOLES);
    localparam int unsigned T_MAX   = (UP_CYCLES > COOL_CYCLES) ? UP_CYCLES : COOL_CYCLES;
    localparam int unsigned TIMER_W = $clog2(T_MAX);
    localparam logic [TIMER_W-1:0] UP_LOAD   = TIMER_W'(UP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] COOL_LOAD = TIMER_W'(COOL_CYCLES - 1);
    localparam logic [SCORE_W-1:0] MISS_LIM  = SCORE_W'(MAX_MISSES);

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W-1:0]   misses_q, misses_d;
    logic                 hit_q, hit_d;
    logic                 miss_q, miss_d;
    logic [7:0]           lfsr_q;
    logic [N_MOLES-1:0]   btn_rise;
    logic [N_MOLES-1:0]   up_mask;
    logic [SCORE_W-1:0]   miss_inc;
    logic                 last_miss;

    btn_edge_bank #(.N(N_MOLES)) u_edges (
        .clk      (clk),
        .n_reset  (n_reset),
        .btn      (btn),
        .btn_rise (btn_rise)
    );

    assign up_mask   = N_MOLES'(1) << idx_q;
    assign miss_inc  = misses_q + 1'b1;
    // A same-cycle clear zeroes the counter, so the limit cannot be reached.
    assign last_miss = !clear && (miss_inc == MISS_LIM);

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            idx_q    <= '0;
            score_q  <= '0;
            misses_q <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            lfsr_q   <= LFSR_SEED;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            lfsr_q   <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        score_d  = score_q;
        misses_d = misses_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (run) state_d = SELECT;
            end
            SELECT: begin
                if (!run) begin
                    state_d = IDLE;
                end else begin
                    // idx_q doubles as prev_idx: never raise the same mole twice in a row.
                    idx_d = lfsr_q[IDX_W-1:0];
                    if (idx_d == idx_q) idx_d = idx_q + 1'b1;
                    timer_d = UP_LOAD;
                    state_d = UP;
                end
            end
            UP: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (btn_rise[idx_q]) begin
                    hit_d   = 1'b1;
                    timer_d = COOL_LOAD;
                    state_d = COOL;
                end else if (timer_q == '0) begin
                    miss_d  = 1'b1;
                    timer_d = COOL_LOAD;
                    state_d = last_miss ? GAME_OVER : COOL;
                end else begin
                    timer_d = timer_q - 1'b1;
`ifdef MOLE_PENALTY_EN
                    if (|(btn_rise & ~up_mask)) begin
                        miss_d = 1'b1;
                        if (last_miss) state_d = GAME_OVER;
                    end
`endif
                end
            end
            COOL: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    state_d = SELECT;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            GAME_OVER: begin
                if (clear) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (hit_d && (score_q != '1)) score_d = score_q + 1'b1;
        if (miss_d) misses_d = miss_inc;
        if (clear) begin
            score_d  = '0;
            misses_d = '0;
        end
    end

    assign mole_onehot = (state_q == UP) ? up_mask : '0;
    assign hit_pulse   = hit_q;
    assign miss_pulse  = miss_q;
    assign score       = score_q;
    assign misses      = misses_q;
    assign game_over   = (state_q == GAME_OVER);

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Scoreboard testbench for mole_round_scheduler with a behavioural game model.
module tb_mole_round_scheduler;

    localparam int N     = 4;
    localparam int UP    = 8;
    localparam int COOL  = 4;
    localparam int MAXM  = 3;
    localparam int SEED  = 'hA5;

    localparam int P_IDLE = 0, P_SEL = 1, P_UP = 2, P_COOL = 3, P_GO = 4;

    logic         clk = 1'b0;
    logic         n_reset = 1'b0;
    logic         run = 1'b0;
    logic         clear = 1'b0;
    logic [N-1:0] btn = '0;
    logic [N-1:0] mole_onehot;
    logic         hit_pulse, miss_pulse, game_over;
    logic [7:0]   score, misses;

    always #5 clk = ~clk;

    mole_round_scheduler #(
        .N_MOLES(N), .UP_CYCLES(UP), .COOL_CYCLES(COOL),
        .SCORE_W(8), .MAX_MISSES(MAXM), .LFSR_SEED(8'hA5)
    ) dut (
        .clk(clk), .n_reset(n_reset), .run(run), .clear(clear), .btn(btn),
        .mole_onehot(mole_onehot), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
        .score(score), .misses(misses), .game_over(game_over)
    );

    typedef struct { bit hit; bit miss; } ev_t;
    ev_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    // Game model: phase, elapsed cycles in the phase, current mole, counters.
    int m_phase = P_IDLE, m_count = 0, m_idx = 0, m_lfsr = SEED, m_bprev = 0;
    int m_score = 0, m_misses = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lfsr_next(input int l);
        int fb;
        fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
        return ((l << 1) & 255) | fb;
    endfunction

    function automatic int exp_mole();
        return (m_phase == P_UP) ? (1 << m_idx) : 0;
    endfunction

    // Advances the model by one clock using the inputs the DUT is about to sample.
    task automatic model_step();
        int edges, old_l, pick;
        bit hit, miss, ends;
        ev_t e;
        if (!n_reset) begin
            m_phase = P_IDLE; m_count = 0; m_idx = 0; m_lfsr = SEED;
            m_bprev = 0; m_score = 0; m_misses = 0;
            return;
        end
        edges   = int'(btn) & ~m_bprev & 15;
        m_bprev = int'(btn);
        old_l   = m_lfsr;
        m_lfsr  = lfsr_next(old_l);
        hit = 0; miss = 0;
        ends = !clear && (m_misses + 1 == MAXM);
        case (m_phase)
            P_IDLE: if (run) m_phase = P_SEL;
            P_SEL: begin
                if (!run) m_phase = P_IDLE;
                else begin
                    pick = old_l % N;
                    if (pick == m_idx) pick = (pick + 1) % N;
                    m_idx = pick; m_count = 0; m_phase = P_UP;
                end
            end
            P_UP: begin
                if (!run) m_phase = P_IDLE;
                else if (((edges >> m_idx) & 1) != 0) begin
                    hit = 1; m_phase = P_COOL; m_count = 0;
                end else if (m_count == UP - 1) begin
                    miss = 1; m_phase = ends ? P_GO : P_COOL; m_count = 0;
                end else begin
                    m_count++;
`ifdef MOLE_PENALTY_EN
                    if ((edges & ~(1 << m_idx)) != 0) begin
                        miss = 1;
                        if (ends) m_phase = P_GO;
                    end
`endif
                end
            end
            P_COOL: begin
                if (!run) m_phase = P_IDLE;
                else if (m_count == COOL - 1) m_phase = P_SEL;
                else m_count++;
            end
            default: if (clear) m_phase = P_IDLE;
        endcase
        if (clear) begin
            m_score = 0; m_misses = 0;
        end else begin
            if (hit && m_score < 255) m_score++;
            if (miss) m_misses++;
        end
        if (hit || miss) begin
            e.hit = hit; e.miss = miss;
            sb.push_back(e);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_phase(input int ph, input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            if (m_phase == ph) return;
            step();
        end
        if (m_phase != ph) begin
            n_checks++; n_fail++;
            $display("FAIL %s: timeout waiting for phase %0d, model phase %0d", nm, ph, m_phase);
        end
    endtask

    // Monitor: per-cycle output checks and pulse scoreboard.
    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            chk("mole_onehot", mole_onehot, exp_mole());
            chk("game_over", game_over, (m_phase == P_GO) ? 1 : 0);
            chk("score", score, m_score);
            chk("misses", misses, m_misses);
            if (hit_pulse || miss_pulse) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL pulse_unexpected: hit=%0b miss=%0b expected none", hit_pulse, miss_pulse);
                end else begin
                    e = sb.pop_front();
                    chk("hit_pulse", hit_pulse, e.hit);
                    chk("miss_pulse", miss_pulse, e.miss);
                end
            end else if (sb.size() != 0) begin
                e = sb.pop_front();
                n_checks++; n_fail++;
                $display("FAIL pulse_missing: got none expected hit=%0b miss=%0b", e.hit, e.miss);
            end
        end
    end

    initial begin
        int s0, len;
        logic [N-1:0] pat;

        // Reset
        n_reset = 0; run = 0;
        step(); step();
        mon_en = 1;
        chk("rst_mole", mole_onehot, 0);
        chk("rst_score", score, 0);
        chk("rst_hit", hit_pulse, 0);
        n_reset = 1;
        step();

        // First round: mole up exactly two cycles after run, then a hit
        run = 1;
        step();
        chk("select_gap", mole_onehot, 0);
        step();
        chk("mole_up_2cyc", (mole_onehot != 0) ? 1 : 0, 1);
        step();
        btn = N'(1 << m_idx);
        step();
        chk("s1_hit", hit_pulse, 1);
        chk("s1_score", score, 1);
        chk("s1_mole_clr", mole_onehot, 0);
        btn = '0;

        // Three idle rounds end the game; clear recovers
        wait_phase(P_GO, 100, "to_game_over");
        chk("go_flag", game_over, 1);
        chk("go_misses", misses, MAXM);
        chk("go_mole", mole_onehot, 0);
        clear = 1;
        step();
        clear = 0;
        chk("clr_score", score, 0);
        chk("clr_misses", misses, 0);
        chk("clr_go", game_over, 0);

        // Hit on the last UP cycle
        wait_phase(P_UP, 40, "s3_up");
        for (int i = 0; i < UP && m_count < UP - 1; i++) step();
        s0 = m_score;
        btn = N'(1 << m_idx);
        step();
        chk("last_hit", hit_pulse, 1);
        chk("last_nomiss", miss_pulse, 0);
        chk("last_score", score, s0 + 1);
        btn = '0;

        // Holding buttons gives a single hit
        wait_phase(P_UP, 40, "s4_up");
        btn = '1;
        step();
        chk("hold_hit", hit_pulse, 1);
        s0 = m_score;
        for (int i = 0; i < 28; i++) step();
        chk("hold_no_rehit", score, s0);
        btn = '0;
        wait_phase(P_UP, 40, "s4_up2");
        btn = N'(1 << m_idx);
        step();
        chk("repress_hit", hit_pulse, 1);
        btn = '0;

        // run dropped mid-UP, then reset mid-UP
        clear = 1; step(); clear = 0;
        wait_phase(P_UP, 40, "s5_up");
        step(); step();
        s0 = m_score;
        run = 0;
        step();
        chk("run0_mole", mole_onehot, 0);
        chk("run0_pulse", hit_pulse | miss_pulse, 0);
        chk("run0_score", score, s0);
        run = 1;
        wait_phase(P_UP, 40, "s5_up2");
        step();
        n_reset = 0;
        step();
        chk("rst_mid_mole", mole_onehot, 0);
        chk("rst_mid_score", score, 0);
        chk("rst_mid_pulse", hit_pulse | miss_pulse, 0);
        n_reset = 1;

        // Wrong-button press
        wait_phase(P_UP, 40, "s6_up");
        btn = N'(1 << ((m_idx + 1) % N));
        step();
`ifdef MOLE_PENALTY_EN
        chk("wrong_miss", miss_pulse, 1);
`else
        chk("wrong_ignored", miss_pulse, 0);
`endif
        chk("wrong_mole_up", mole_onehot, 1 << m_idx);
        btn = '0;
        step();
        btn = N'(1 << m_idx);
        step();
        chk("after_wrong_hit", hit_pulse, 1);
        btn = '0;

        // Randomised play
        for (int c = 0; c < 2000; c += len) begin
            len = $urandom_range(1, 6);
            if ($urandom_range(0, 99) < 35 && m_phase == P_UP) pat = N'(1 << m_idx);
            else pat = N'($urandom_range(0, 15));
            for (int k = 0; k < len; k++) begin
                btn     = pat;
                run     = ($urandom_range(0, 99) != 0);
                clear   = ($urandom_range(0, 149) == 0);
                n_reset = ($urandom_range(0, 499) != 0);
                step();
            end
        end
        clear = 0; n_reset = 1; btn = '0; run = 0;
        step(); step();
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mole_round_scheduler.md
Name: mole_round_scheduler

Overview:
- Game controller that sequences mole rounds: picks a pseudo-random mole, holds it up for a fixed window, and judges player button presses as hit or miss.
- Owns per-button rising-edge detection for the raw (already debounced) button levels, the round timer, and the score and miss counters.
- Sits between the button debouncers and the display/score logic; drives the mole LEDs and the game-over flag.

Parameters:
- N_MOLES, 4, number of moles/buttons; must be a power of 2, range 2..8.
- UP_CYCLES, 50000000, clock cycles a mole stays up; must be ≥2.
- COOL_CYCLES, 25000000, blank cycles between rounds; must be ≥1.
- SCORE_W, 8, width of the score and miss counters.
- MAX_MISSES, 5, miss count that ends the game; must be in 1..2^SCORE_W-1.
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- n_reset  in  1  active-low reset, synchronous to clk.
- run  in  1  level; high = game running.
- clear  in  1  one-cycle pulse; zeroes score and misses and leaves GAME_OVER.
- btn  in  N_MOLES  debounced button levels.
- mole_onehot  out  N_MOLES  currently raised mole.
- hit_pulse  out  1  one-cycle pulse on a correct hit.
- miss_pulse  out  1  one-cycle pulse when a window expires without a hit.
- score  out  SCORE_W  hit count, saturating.
- misses  out  SCORE_W  miss count.
- game_over  out  1  high while in GAME_OVER.

Behaviour:
- Reset is synchronous: n_reset is sampled low on a rising clk edge. Reset values: state=IDLE, mole_onehot=0, hit_pulse=0, miss_pulse=0, score=0, misses=0, game_over=0, btn_d=0, lfsr=LFSR_SEED, prev_idx=0.
- Edge detection: btn_d <= btn every cycle. edge[i] = btn[i] & ~btn_d[i], combinational.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every cycle outside reset.
- IDLE: outputs low. Go to SELECT when run=1.
- SELECT (1 cycle):
  - idx = lfsr[log2(N_MOLES)-1:0].
  - If idx==prev_idx, use idx+1 modulo N_MOLES.
  - Store idx in prev_idx, load timer=UP_CYCLES-1, go to UP.
- UP: mole_onehot = 1<<idx. Each cycle, checks are applied in this order:
  - edge[idx]=1: hit_pulse=1 next cycle; score+1, saturating at all-ones; go to COOL.
  - else timer==0: miss_pulse=1 next cycle; misses+1; go to GAME_OVER if the new misses == MAX_MISSES, otherwise COOL.
  - else timer-1.
  - Latency: a button sampled high in cycle t gives hit_pulse in cycle t+1, and mole_onehot is cleared in cycle t+1.
- Simultaneous events in UP:
  - A hit in the same cycle as timer==0 counts as a hit.
  - Edges on other buttons are ignored (see the optional feature).
  - Several buttons rising together: a hit counts if the correct one is among them.
- COOL: mole_onehot=0, timer counts down from COOL_CYCLES-1. At 0, go to SELECT.
- GAME_OVER: game_over=1, mole_onehot=0. Leaves only on clear, going to IDLE.
- run=0 in SELECT, UP or COOL: go to IDLE next cycle. Score and misses are held and no pulse is issued. run has no effect in GAME_OVER.
- clear (any state): score=0 and misses=0 next cycle. clear takes priority over a same-cycle increment. From GAME_OVER, go to IDLE. In other states, the state is unaffected.
- Reset mid-round: everything returns to its reset value and no pulse is emitted.

Optional Feature:
- MOLE_PENALTY_EN defined: in UP, an edge on any button other than idx, with no edge on idx in the same cycle, is a wrong press.
  - miss_pulse=1 next cycle and misses+1, with the same MAX_MISSES check.
  - The mole stays up and the timer continues.
  - If the timer hits 0 in that same cycle, only one miss is counted.
- MOLE_PENALTY_EN undefined: wrong presses are ignored.

Decomposition:
- Shared package mole_game_pkg holds:
  - state enum: IDLE, SELECT, UP, COOL, GAME_OVER;
  - the LFSR tap mask constant;
  - the clog2-based index width helper.
- One sub-module: btn_edge_bank, an N_MOLES-wide registered rising-edge detector with a synchronous active-low reset.

Test Plan:
All scenarios use N_MOLES=4, UP_CYCLES=8, COOL_CYCLES=4, MAX_MISSES=3, SCORE_W=8, LFSR_SEED=8'hA5.
- Reset then run=1 → mole_onehot nonzero exactly 2 cycles after run is first sampled high. Hold the selected button high from cycle 3 → hit_pulse one cycle later, score=1, mole_onehot=0 on that same cycle.
- No presses for 3 rounds → miss_pulse after 8 up-cycles each round; misses=3 → game_over=1, mole_onehot=0. Assert clear → score=0, misses=0, state IDLE, game_over=0.
- Correct button rises on the last UP cycle (timer==0) → hit_pulse, no miss_pulse, score+1.
- Hold a button high across the window → only one hit; no further hit in later rounds until it is released and pressed again.
- Deassert run mid-UP → mole_onehot=0 next cycle, no pulse, score held. Pulse n_reset low mid-UP → all outputs at reset values on the next cycle.
- With MOLE_PENALTY_EN: press a wrong button in UP → miss_pulse, mole still up; then the correct button → hit_pulse. Without the macro → the wrong press has no effect.
